// File: rtl/l_stf_gen.sv
// L-STF sample generator: streams num_rep 16-sample short-training periods over valid/ready,
// with optional half-amplitude edge windowing and I/Q width conversion.
module l_stf_gen #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_REP   = 15,
    parameter int unsigned WINDOW_EN = 1,
    localparam int unsigned RepW     = $clog2(MAX_REP + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [RepW-1:0]     num_rep,
    input  logic                abort,
    output logic                busy,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*DATA_W-1:0] m_data,
    output logic                m_last,
    output logic                done
);

    localparam logic Win = (WINDOW_EN != 0);

    typedef enum logic [1:0] {StIdle, StRun, StTail} state_e;

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [RepW-1:0]     per_q, per_d, nrep_q, nrep_d;
    logic                valid_q, valid_d, last_q, last_d, done_q, done_d, busy_q, busy_d;
    logic [2*DATA_W-1:0] data_q, data_d;
    logic                fire, last_period, at_end;

    function automatic logic [31:0] stf_word(input logic [3:0] i);
        unique case (i)
            4'd0, 4'd8:   return 32'h05E305E3;
            4'd1, 4'd7:   return 32'hEF0C004D;
            4'd2, 4'd6:   return 32'hFE47F5F3;
            4'd3, 4'd5:   return 32'h1246FE61;
            4'd4:         return 32'h0BC70000;
            4'd9, 4'd15:  return 32'h004DEF0C;
            4'd10, 4'd14: return 32'hF5F3FE47;
            4'd11, 4'd13: return 32'hFE611246;
            default:      return 32'h00000BC7;
        endcase
    endfunction

    // Place the 16-bit value at the top of DATA_W: truncates LSBs or pads zeros as needed.
    function automatic logic [DATA_W-1:0] fit(input logic [15:0] c);
        return DATA_W'({c, {DATA_W{1'b0}}} >> 16);
    endfunction

    function automatic logic [2*DATA_W-1:0] beat(input logic [3:0] i, input logic half);
        logic [31:0] w;
        logic [15:0] i_c, q_c;
        w   = stf_word(i);
        i_c = half ? {w[31], w[31:17]} : w[31:16];
        q_c = half ? {w[15], w[15:1]} : w[15:0];
        return {fit(i_c), fit(q_c)};
    endfunction

    assign fire        = valid_q && m_ready;
    assign last_period = (per_q == nrep_q - RepW'(1));
    assign at_end      = (idx_q == 4'd15) && last_period;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && !busy_q && num_rep != '0) state_d = StRun;
            StRun:  if (fire && at_end) state_d = Win ? StTail : StIdle;
            StTail: if (fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_comb begin
        idx_d   = idx_q;
        per_d   = per_q;
        nrep_d  = nrep_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // busy only lingers here for the single done cycle of an empty burst
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    nrep_d = num_rep;
                    busy_d = 1'b1;
                    idx_d  = 4'd0;
                    per_d  = '0;
                    if (num_rep == '0) begin
                        done_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = beat(4'd0, Win);
                        last_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (fire) begin
                    if (at_end) begin
                        if (Win) begin
                            data_d = beat(4'd0, 1'b1);
                            last_d = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            data_d  = '0;
                            idx_d   = 4'd0;
                            per_d   = '0;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd15) per_d = per_q + RepW'(1);
                        data_d = beat(idx_q + 4'd1, 1'b0);
                        last_d = !Win && (idx_q == 4'd14) && last_period;
                    end
                end
            end
            StTail: begin
                if (fire) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    data_d  = '0;
                    idx_d   = 4'd0;
                    per_d   = '0;
                end
            end
            default: ;
        endcase
        if (abort) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            data_d  = '0;
            idx_d   = 4'd0;
            per_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= 4'd0;
            per_q   <= '0;
            nrep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            per_q   <= per_d;
            nrep_q  <= nrep_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    assign busy    = busy_q;
    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_last  = last_q;
    assign done    = done_q;

endmodule

// File: tb/tb_l_stf_gen.sv
// Scoreboard bench for l_stf_gen: three instances (plain 16-bit, windowed 16-bit, plain 12-bit)
// driven one at a time; a monitor pops expected beats as each transfer happens.
module tb_l_stf_gen;

    logic        clk = 1'b0;
    logic        reset, abort, m_ready;
    logic [3:0]  num_rep;
    logic        start [3];
    logic        bsy [3], vld [3], lst [3], don [3];
    logic [31:0] dat0, dat1;
    logic [23:0] dat2;

    always #5 clk = ~clk;

    l_stf_gen #(.DATA_W(16), .MAX_REP(15), .WINDOW_EN(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .num_rep(num_rep), .abort(abort),
        .busy(bsy[0]), .m_valid(vld[0]), .m_ready(m_ready), .m_data(dat0), .m_last(lst[0]),
        .done(don[0]));
    l_stf_gen #(.DATA_W(16), .MAX_REP(15), .WINDOW_EN(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .num_rep(num_rep), .abort(abort),
        .busy(bsy[1]), .m_valid(vld[1]), .m_ready(m_ready), .m_data(dat1), .m_last(lst[1]),
        .done(don[1]));
    l_stf_gen #(.DATA_W(12), .MAX_REP(15), .WINDOW_EN(0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .num_rep(num_rep), .abort(abort),
        .busy(bsy[2]), .m_valid(vld[2]), .m_ready(m_ready), .m_data(dat2), .m_last(lst[2]),
        .done(don[2]));

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        expq [$];
    logic [31:0] cap [$];
    logic [31:0] tbl [16] = '{32'h05E305E3, 32'hEF0C004D, 32'hFE47F5F3, 32'h1246FE61,
                              32'h0BC70000, 32'h1246FE61, 32'hFE47F5F3, 32'hEF0C004D,
                              32'h05E305E3, 32'h004DEF0C, 32'hF5F3FE47, 32'hFE611246,
                              32'h00000BC7, 32'hFE611246, 32'hF5F3FE47, 32'h004DEF0C};
    int          errors = 0;
    int          checks = 0;
    bit          mon_skip = 1'b0;
    int          rdy_mode = 0;
    logic [31:0] hold_d [3];
    logic        hold_l [3];
    bit          stalled [3];

    function automatic logic [31:0] dat_of(input int d);
        case (d)
            0:       return dat0;
            1:       return dat1;
            default: return {8'h00, dat2};
        endcase
    endfunction

    // Expected beat b of an n-beat burst on instance d.
    function automatic logic [31:0] model(input int d, input int b, input int n);
        logic [31:0] w;
        w = tbl[b % 16];
        if (d == 1 && (b == 0 || b == n - 1)) w = {w[31], w[31:17], w[15], w[15:1]};
        if (d == 2) w = {8'h00, w[31:20], w[15:4]};
        return w;
    endfunction

    function automatic logic [31:0] capv(input int i);
        if (i < cap.size()) return cap[i];
        return 32'hxxxxxxxx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (stalled[d] && vld[d]) begin
                chk("stall_data", dat_of(d), hold_d[d]);
                chk("stall_last", 32'(lst[d]), 32'(hold_l[d]));
            end
            if (vld[d] && m_ready && !mon_skip) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: dut %0d got %h, expected none", d, dat_of(d));
                end else begin
                    e = expq.pop_front();
                    chk("beat_dut", 32'(d), 32'(e.dut));
                    chk("beat_data", dat_of(d), e.data);
                    chk("beat_last", 32'(lst[d]), 32'(e.last));
                end
                cap.push_back(dat_of(d));
            end
            stalled[d] = vld[d] && !m_ready;
            hold_d[d]  = dat_of(d);
            hold_l[d]  = lst[d];
        end
    end

    task automatic burst(input int d, input int nrep, input int nbeats, input bit exact);
        int beats = 0;
        int cyc = 0;
        bit prev_last = 1'b0;
        for (int b = 0; b < nbeats; b++) expq.push_back({2'(d), model(d, b, nbeats), b == nbeats - 1});
        cap.delete();
        num_rep  = 4'(nrep);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        chk("busy_after_start", 32'(bsy[d]), 32'd1);
        chk("valid_latency", 32'(vld[d]), 32'(nbeats > 0));
        while (!don[d] && cyc < 4000) begin
            if (vld[d] && m_ready) begin
                beats++;
                prev_last = lst[d];
            end else begin
                prev_last = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 32'(don[d]), 32'd1);
        chk("beat_count", 32'(beats), 32'(nbeats));
        if (nbeats > 0) chk("last_then_done", 32'(prev_last), 32'd1);
        if (exact) chk("burst_cycles", 32'(cyc), 32'(nbeats));
        chk("busy_at_done", 32'(bsy[d]), 32'(nbeats == 0));
        @(negedge clk);
        chk("done_width", 32'(don[d]), 32'd0);
        chk("busy_after", 32'(bsy[d]), 32'd0);
        chk("idle_valid", 32'(vld[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int cyc;
        reset   = 1'b1;
        abort   = 1'b0;
        num_rep = 4'd0;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", 32'(bsy[d]), 32'd0);
            chk("rst_valid", 32'(vld[d]), 32'd0);
            chk("rst_last", 32'(lst[d]), 32'd0);
            chk("rst_done", 32'(don[d]), 32'd0);
            chk("rst_data", dat_of(d), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Plain 10-period burst at full throughput
        burst(0, 10, 160, 1'b1);
        chk("s1_beat0", capv(0), 32'h05E305E3);
        chk("s1_beat17", capv(17), 32'hEF0C004D);
        chk("s1_beat159", capv(159), 32'h004DEF0C);

        // Windowed burst: halved first and tail beats
        burst(1, 10, 161, 1'b1);
        chk("s2_beat0", capv(0), 32'h02F102F1);
        chk("s2_beat16", capv(16), 32'h05E305E3);
        chk("s2_beat160", capv(160), 32'h02F102F1);

        // Random backpressure
        rdy_mode = 1;
        burst(0, 10, 160, 1'b0);
        rdy_mode = 0;
        chk("s3_count", 32'(cap.size()), 32'd160);
        chk("s3_beat159", capv(159), 32'h004DEF0C);
        repeat (2) @(negedge clk);

        // Empty burst
        burst(0, 0, 0, 1'b0);

        // Abort at beat 40 with a simultaneous start
        for (int b = 0; b < 40; b++) expq.push_back({2'd0, model(0, b, 160), 1'b0});
        num_rep  = 4'd10;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cyc < 1000) begin
            if (vld[0] && m_ready) cnt++;
            if (cnt == 40) break;
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach", 32'(cnt), 32'd40);
        @(posedge clk);
        #1;
        abort    = 1'b1;
        start[0] = 1'b1;
        mon_skip = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        start[0] = 1'b0;
        @(negedge clk);
        mon_skip = 1'b0;
        chk("abort_valid", 32'(vld[0]), 32'd0);
        chk("abort_busy", 32'(bsy[0]), 32'd0);
        chk("abort_last", 32'(lst[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 32'(don[0]), 32'd0);
            chk("abort_idle", 32'(vld[0]), 32'd0);
            @(negedge clk);
        end
        chk("abort_drained", 32'(expq.size()), 32'd0);

        // abort beats start while idle
        abort    = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        start[0] = 1'b0;
        chk("abort_start_busy", 32'(bsy[0]), 32'd0);
        chk("abort_start_valid", 32'(vld[0]), 32'd0);
        @(negedge clk);

        burst(0, 1, 16, 1'b1);
        chk("restart_beat0", capv(0), 32'h05E305E3);

        // 12-bit output width
        burst(2, 2, 32, 1'b1);
        chk("w12_beat1", capv(1), 32'h00EF0004);
        chk("w12_beat3", capv(3), 32'h00124FE6);
        chk("w12_count", 32'(cap.size()), 32'd32);

        repeat (2) @(negedge clk);
        chk("final_queue_empty", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l_stf_gen.md
Name: l_stf_gen

Overview:
Parametrised legacy short training field (L-STF) generator for the OFDM TX chain. It replaces a bare 16-entry sample ROM with a self-sequencing source. On a start pulse it streams a runtime-selected number of 16-sample STF periods over a valid/ready interface, with optional 802.11 edge windowing and a configurable I/Q component width. It sits ahead of the preamble/data mux feeding the TX sample FIFO.

Parameters:
DATA_W, 16, width of each I and Q component on the output (legal 8..24).
MAX_REP, 15, maximum number of STF periods. Sets the width of num_rep as clog2(MAX_REP+1).
WINDOW_EN, 1, 1 = halve the first sample and append a halved tail sample; 0 = plain periods.

Ports:
clk  in  1  TX clock.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a burst; honoured only in IDLE.
num_rep  in  clog2(MAX_REP+1)  STF periods per burst; sampled on accepted start.
abort  in  1  synchronous burst cancel.
busy  out  1  high from accepted start until return to IDLE.
m_valid  out  1  sample valid.
m_ready  in  1  downstream ready.
m_data  out  2*DATA_W  I in [2*DATA_W-1:DATA_W], Q in [DATA_W-1:0], two's complement.
m_last  out  1  marks the final sample of the burst.
done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Internal 16-entry table of 16-bit I/Q words, {I,Q} hex, index 0..15:
  05E305E3 EF0C004D FE47F5F3 1246FE61 0BC70000 1246FE61 FE47F5F3 EF0C004D 05E305E3 004DEF0C F5F3FE47 FE611246 00000BC7 FE611246 F5F3FE47 004DEF0C
- Reset: state=IDLE. m_valid, m_last, done and busy are 0. m_data is 0. Counters are 0.
- States: IDLE -> RUN -> (TAIL if WINDOW_EN) -> IDLE.
  - IDLE: on start, latch num_rep and assert busy next cycle. If num_rep=0, emit no beats, pulse done the next cycle and stay in IDLE. Otherwise go to RUN with m_valid=1 and sample 0 presented in the cycle after start (latency 1).
  - RUN: a beat transfers when m_valid&&m_ready. On each transfer, advance the 4-bit sample index (wraps 15->0) and increment the period counter on wrap. After the beat with index 15 of period num_rep-1, go to TAIL if WINDOW_EN, else to IDLE.
  - TAIL: present one sample = halved table[0], then go to IDLE on transfer.
- Burst length: 16*num_rep beats, plus 1 when WINDOW_EN.
- m_last is high only with the final beat of the burst.
- done pulses for one cycle in the cycle after the final transfer. busy falls in that same cycle.
- Output is registered. While m_valid && !m_ready, m_data and m_last hold stable, and neither the index nor the counters advance.
- Windowing (WINDOW_EN=1): the first beat of the burst and the tail beat are table value arithmetic-shifted right by 1, per component, on 16 bits.
- Width conversion, applied after windowing:
  - DATA_W<16: keep bits [15:16-DATA_W] (truncate LSBs).
  - DATA_W>16: left-shift by DATA_W-16 with zero LSBs.
  - DATA_W=16: pass through.
- abort: in any state, the next cycle is IDLE with m_valid=0, m_last=0 and busy=0. No done pulse is generated. abort wins over a simultaneous start.
- start while busy is ignored.
- reset mid-burst behaves as abort and clears all counters.

Test Plan:
1. DATA_W=16, WINDOW_EN=0, num_rep=10, m_ready=1:
   - valid asserts 1 cycle after start and 160 consecutive beats follow.
   - beat0=0x05E305E3, beat17=0xEF0C004D, beat159=0x004DEF0C with m_last=1.
   - done pulses exactly 1 cycle after beat159.
2. WINDOW_EN=1, num_rep=10:
   - 161 beats.
   - beat0=0x02F102F1, beat16=0x05E305E3, beat160=0x02F102F1 with m_last=1.
3. Random m_ready toggling (~50% duty) over a full burst:
   - beat sequence is identical to scenario 1.
   - m_data and m_last are stable while stalled.
   - no beat is dropped or duplicated.
4. num_rep=0:
   - no m_valid.
   - done pulses 1 cycle after start.
   - busy high for one cycle only.
5. abort asserted at beat 40, with start pulsed in the same cycle as a later abort:
   - m_valid=0 the next cycle and no done pulse.
   - a fresh start afterwards restarts at beat0=0x05E305E3.
6. DATA_W=12, WINDOW_EN=0:
   - beat1 I=0xEF0, Q=0x004.
   - beat3 I=0x124, Q=0xFE6.
   - burst length unchanged at 16*num_rep.
